viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Survivor-path memory and traceback stage, downstream of the add-compare-select / max-and-index compare stage.
- Forward pass: per trellis step, it stores the winning predecessor index (backpointer) for every state.
- On command, it walks the stored backpointers backwards from a given final state and streams one decoded state per step over a valid/ready handshake.

Parameters:
- POS_num_bit, 4, width of a state index; state count N_STATES = 2**POS_num_bit.
- T_BITS, 4, width of the step counter; memory depth T_DEPTH = 2**T_BITS trellis steps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- bp_valid  input  1  backpointer write request.
- bp_ready  output  1  write accepted this cycle when bp_valid is also high.
- bp_state  input  POS_num_bit  state being written.
- bp_index  input  POS_num_bit  winning predecessor of bp_state (index_of_max from the compare stage).
- bp_last  input  1  marks the final write of the current trellis step.
- tb_start  input  1  single-cycle traceback request.
- tb_state  input  POS_num_bit  final (best) state at which traceback starts.
- out_valid  output  1  decoded state available.
- out_ready  input  1  consumer accepts.
- out_state  output  POS_num_bit  decoded state.
- out_step  output  T_BITS  trellis step of out_state.
- out_last  output  1  high with the step-0 output.
- busy  output  1  high in TRACE.
- full  output  1  step counter has reached T_DEPTH.

Behaviour:
- Storage: array mem[T_DEPTH][N_STATES] of POS_num_bit bits. The array is not reset; its contents are undefined until written.
- Registers: step_cnt (T_BITS+1 bits), t (T_BITS bits), cur (POS_num_bit bits), and the FSM state.
- Reset values: FSM=FILL, step_cnt=0, t=0, cur=0, out_valid=0, out_last=0, busy=0, full=0.
- Reset is honoured at any time, including mid-traceback: any partially emitted sequence is abandoned and no further outputs appear.
- full = (step_cnt == T_DEPTH), registered.
- bp_ready = (FSM==FILL) && !full. It is combinational from state only, never from inputs.
- FILL:
  - A write fires when bp_valid && bp_ready: mem[step_cnt][bp_state] <= bp_index.
  - If bp_last is also high, step_cnt increments by 1.
  - Rewriting the same (step, state) within a step overwrites; the last write wins.
  - bp_valid while bp_ready=0 is ignored, with no side effects.
- FILL, tb_start taken with effective count C > 0:
  - C = step_cnt, plus 1 if a bp_last write fires in the same cycle. That write is performed and included.
  - Latch cur <= tb_state and t <= C-1, then go to TRACE. busy=1 and out_valid=1 from the next cycle.
- FILL, tb_start with C == 0: ignored and the FSM stays in FILL. A same-cycle non-last write still occurs.
- tb_start in TRACE is ignored.
- TRACE:
  - out_state=cur, out_step=t, out_last=(t==0). All outputs are registered and held stable while out_ready=0.
  - On out_valid && out_ready with t>0: cur <= mem[t][cur] and t <= t-1. The next output appears the following cycle, so with out_ready held high there is one output per cycle.
  - On out_valid && out_ready with t==0: go to FILL, step_cnt <= 0, out_valid <= 0, busy <= 0.
  - No bp writes are accepted in TRACE.
- Latency: first output 1 cycle after tb_start. A C-step traceback completes in exactly C cycles with out_ready held high.
- Full boundary: at step_cnt=T_DEPTH, writes stall via bp_ready=0 until a traceback is taken. A traceback from full emits T_DEPTH outputs, steps T_DEPTH-1..0.
- State indices wrap naturally at POS_num_bit bits. No range checks are needed because N_STATES = 2**POS_num_bit.

Test Plan:
- Basic trace, defaults:
  - Step 0: write all 16 states with bp=0, bp_last on state 15.
  - Step 1: state 7 -> bp 3; step 2: state 5 -> bp 7, each closed with bp_last.
  - tb_start with tb_state=5, out_ready=1 -> outputs (step2, 5), (step1, 7), (step0, 3, out_last=1) on consecutive cycles.
  - Then busy=0, bp_ready=1, step_cnt=0.
- Backpressure: same setup, out_ready low for 3 cycles after the first output -> (2,5) held stable. Sequence is unchanged, with no duplicates or drops.
- Simultaneous: tb_start in the same cycle as a bp_last write that closes step 2 (state 5 -> bp 7) -> that step is included; the first output is (step2, 5).
- Empty/full:
  - tb_start with step_cnt=0 -> no out_valid, FSM stays in FILL.
  - Write 16 complete steps -> full=1, bp_ready=0. A 17th write is ignored (mem unchanged).
  - A traceback then emits 16 outputs, steps 15..0.
- Reset mid-trace: assert rst after the 2nd output of a 3-step trace -> out_valid=0, busy=0, full=0 immediately. A new fill and traceback work normally afterwards.
- Overwrite: in step 0, write state 2 -> bp 1, then state 2 -> bp 9, then bp_last. tb_state=2 at C=1 -> single output (0, 2, out_last=1); a 2-step variant proves bp 9 is used.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Survivor-path memory and traceback stage for a Viterbi decoder.
// Forward pass stores one backpointer per state per trellis step; on request the
// stored backpointers are walked from a final state down to step 0, one decoded
// state per valid/ready handshake.
module viterbi_traceback #(
    parameter int POS_num_bit = 4,
    parameter int T_BITS      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bp_valid,
    output logic                   bp_ready,
    input  logic [POS_num_bit-1:0] bp_state,
    input  logic [POS_num_bit-1:0] bp_index,
    input  logic                   bp_last,
    input  logic                   tb_start,
    input  logic [POS_num_bit-1:0] tb_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [POS_num_bit-1:0] out_state,
    output logic [T_BITS-1:0]      out_step,
    output logic                   out_last,
    output logic                   busy,
    output logic                   full
);

    localparam int N_STATES = 2 ** POS_num_bit;
    localparam int T_DEPTH  = 2 ** T_BITS;
    localparam logic [T_BITS:0] C_DEPTH = (T_BITS + 1)'(T_DEPTH);

    typedef enum logic {
        S_FILL,
        S_TRACE
    } state_t;

    state_t                 r_state;
    logic [POS_num_bit-1:0] r_mem [T_DEPTH][N_STATES];
    logic [T_BITS:0]        r_step_cnt;
    logic [T_BITS-1:0]      r_t;
    logic [POS_num_bit-1:0] r_cur;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_busy;
    logic                   r_full;

    logic                   w_bp_ready;
    logic                   w_wr;
    logic                   w_close;
    logic [T_BITS:0]        w_cnt_eff;
    logic [T_BITS:0]        w_cnt_m1;
    logic [POS_num_bit-1:0] w_back;

    // Write acceptance depends on registered state only.
    assign w_bp_ready = (r_state == S_FILL) && !r_full;
    assign w_wr       = bp_valid && w_bp_ready;
    assign w_close    = w_wr && bp_last;
    // Step count including a step being closed in this very cycle.
    assign w_cnt_eff  = r_step_cnt + (T_BITS + 1)'(w_close);
    assign w_cnt_m1   = w_cnt_eff - (T_BITS + 1)'(1);
    assign w_back     = r_mem[r_t][r_cur];

    assign bp_ready  = w_bp_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_cur;
    assign out_step  = r_t;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign full      = r_full;

    // Backpointer storage; deliberately not reset. Writes only happen below
    // T_DEPTH, so the low T_BITS of the step count address the row.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_step_cnt[T_BITS-1:0]][bp_state] <= bp_index;
        end
    end

    // Fill / traceback control with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_step_cnt  <= '0;
            r_t         <= '0;
            r_cur       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    r_step_cnt <= w_cnt_eff;
                    r_full     <= (w_cnt_eff == C_DEPTH);
                    if (tb_start && (w_cnt_eff != '0)) begin
                        r_state     <= S_TRACE;
                        r_cur       <= tb_state;
                        r_t         <= w_cnt_m1[T_BITS-1:0];
                        r_out_valid <= 1'b1;
                        r_out_last  <= (w_cnt_m1 == '0);
                        r_busy      <= 1'b1;
                    end
                end
                S_TRACE: begin
                    if (r_out_valid && out_ready) begin
                        if (r_t != '0) begin
                            r_cur      <= w_back;
                            r_t        <= r_t - T_BITS'(1);
                            r_out_last <= (r_t == T_BITS'(1));
                        end else begin
                            r_state     <= S_FILL;
                            r_step_cnt  <= '0;
                            r_full      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: vector table of fill/trace scenarios
// plus hand-written sequences for backpressure, same-cycle start, empty/full,
// reset mid-trace and overwrite.
module tb_viterbi_traceback;

    logic       clk = 1'b0;
    logic       rst;
    logic       bp_valid;
    logic       bp_ready;
    logic [3:0] bp_state;
    logic [3:0] bp_index;
    logic       bp_last;
    logic       tb_start;
    logic [3:0] tb_state;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_state;
    logic [3:0] out_step;
    logic       out_last;
    logic       busy;
    logic       full;

    int total = 0;
    int bad   = 0;

    viterbi_traceback #(.POS_num_bit(4), .T_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bp_valid  (bp_valid),
        .bp_ready  (bp_ready),
        .bp_state  (bp_state),
        .bp_index  (bp_index),
        .bp_last   (bp_last),
        .tb_start  (tb_start),
        .tb_state  (tb_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_step  (out_step),
        .out_last  (out_last),
        .busy      (busy),
        .full      (full)
    );

    always #5 clk = ~clk;

    // Traceback scenarios over a formula fill: mem[s][x] = (x + s + 1) mod 16.
    // exp_st[k] is the k-th emitted state (step c-1-k).
    typedef struct packed {
        logic [3:0]      tb_st;
        logic [4:0]      c;
        logic [3:0][3:0] exp_st;
    } vec_t;

    vec_t       vecs [4];
    logic [3:0] fexp [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bp_write(input logic [3:0] s, input logic [3:0] i, input logic l);
        bp_valid = 1'b1;
        bp_state = s;
        bp_index = i;
        bp_last  = l;
        tick();
        bp_valid = 1'b0;
        bp_last  = 1'b0;
    endtask

    task automatic fill_formula(input int unsigned n);
        for (int unsigned s = 0; s < n; s++)
            for (int unsigned x = 0; x < 16; x++)
                bp_write(4'(x), 4'(x + s + 1), x == 15);
    endtask

    // Steps 0..1 of the basic scenario; step 2 is closed by the caller.
    task automatic fill_basic_01();
        for (int unsigned x = 0; x < 16; x++)
            bp_write(4'(x), 4'd0, x == 15);
        bp_write(4'd7, 4'd3, 1'b1);
    endtask

    task automatic start_tb(input logic [3:0] st);
        tb_start = 1'b1;
        tb_state = st;
        tick();
        tb_start = 1'b0;
    endtask

    // Check the presented output, then let the handshake happen (out_ready high).
    task automatic expect_out(input string nm, input logic [3:0] st,
                              input logic [3:0] stp, input logic lst);
        chk({nm, ".valid"}, 32'(out_valid), 32'd1);
        chk({nm, ".state"}, 32'(out_state), 32'(st));
        chk({nm, ".step"},  32'(out_step),  32'(stp));
        chk({nm, ".last"},  32'(out_last),  32'(lst));
        tick();
    endtask

    task automatic expect_idle(input string nm);
        chk({nm, ".valid"}, 32'(out_valid), 32'd0);
        chk({nm, ".busy"},  32'(busy),      32'd0);
        chk({nm, ".ready"}, 32'(bp_ready),  32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{tb_st: 4'd5,  c: 5'd3, exp_st: {4'd0, 4'd10, 4'd8, 4'd5}};
        vecs[1] = '{tb_st: 4'd15, c: 5'd2, exp_st: {4'd0, 4'd0,  4'd1, 4'd15}};
        vecs[2] = '{tb_st: 4'd0,  c: 5'd4, exp_st: {4'd9, 4'd7,  4'd4, 4'd0}};
        vecs[3] = '{tb_st: 4'd9,  c: 5'd1, exp_st: {4'd0, 4'd0,  4'd0, 4'd9}};
        fexp = '{4'd0, 4'd0, 4'd15, 4'd13, 4'd10, 4'd6, 4'd1, 4'd11,
                 4'd4, 4'd12, 4'd3, 4'd9, 4'd14, 4'd2, 4'd5, 4'd7};

        rst = 1'b1; bp_valid = 1'b0; bp_state = '0; bp_index = '0; bp_last = 1'b0;
        tb_start = 1'b0; tb_state = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.last",  32'(out_last),  32'd0);
        chk("rst.busy",  32'(busy),      32'd0);
        chk("rst.full",  32'(full),      32'd0);
        chk("rst.ready", 32'(bp_ready),  32'd1);
        rst = 1'b0;
        tick();

        // Basic three-step trace
        fill_basic_01();
        bp_write(4'd5, 4'd7, 1'b1);
        start_tb(4'd5);
        chk("basic.busy", 32'(busy), 32'd1);
        chk("basic.bprdy", 32'(bp_ready), 32'd0);
        expect_out("basic0", 4'd5, 4'd2, 1'b0);
        expect_out("basic1", 4'd7, 4'd1, 1'b0);
        expect_out("basic2", 4'd3, 4'd0, 1'b1);
        expect_idle("basic.end");

        // Empty: step count is 0 after the trace, so tb_start is ignored
        start_tb(4'd3);
        expect_idle("empty1");
        tick();
        expect_idle("empty2");

        // Backpressure: first output held for 3 extra cycles
        fill_basic_01();
        bp_write(4'd5, 4'd7, 1'b1);
        out_ready = 1'b0;
        start_tb(4'd5);
        for (int i = 0; i < 4; i++) begin
            chk("bp.hold.valid", 32'(out_valid), 32'd1);
            chk("bp.hold.state", 32'(out_state), 32'd5);
            chk("bp.hold.step",  32'(out_step),  32'd2);
            if (i < 3) tick();
        end
        out_ready = 1'b1;
        expect_out("bp0", 4'd5, 4'd2, 1'b0);
        expect_out("bp1", 4'd7, 4'd1, 1'b0);
        expect_out("bp2", 4'd3, 4'd0, 1'b1);
        expect_idle("bp.end");

        // tb_start in the same cycle as the write that closes step 2
        fill_basic_01();
        bp_valid = 1'b1; bp_state = 4'd5; bp_index = 4'd7; bp_last = 1'b1;
        tb_start = 1'b1; tb_state = 4'd5;
        tick();
        bp_valid = 1'b0; bp_last = 1'b0; tb_start = 1'b0;
        expect_out("sim0", 4'd5, 4'd2, 1'b0);
        expect_out("sim1", 4'd7, 4'd1, 1'b0);
        expect_out("sim2", 4'd3, 4'd0, 1'b1);
        expect_idle("sim.end");

        // Full: 16 steps, then a 17th closing write must be ignored
        fill_formula(16);
        chk("full.flag",  32'(full),     32'd1);
        chk("full.ready", 32'(bp_ready), 32'd0);
        bp_write(4'd0, 4'd14, 1'b1);
        chk("full.flag2", 32'(full),     32'd1);
        start_tb(4'd0);
        for (int unsigned k = 0; k < 16; k++)
            expect_out("full", fexp[k], 4'(15 - k), k == 15);
        expect_idle("full.end");
        chk("full.cleared", 32'(full), 32'd0);

        // Reset after the 2nd output of a 3-step trace
        fill_formula(3);
        start_tb(4'd5);
        expect_out("rmt0", 4'd5, 4'd2, 1'b0);
        expect_out("rmt1", 4'd8, 4'd1, 1'b0);
        rst = 1'b1;
        #1;
        chk("rmt.valid", 32'(out_valid), 32'd0);
        chk("rmt.busy",  32'(busy),      32'd0);
        chk("rmt.full",  32'(full),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rmt.after.valid", 32'(out_valid), 32'd0);

        // Table-driven fill/trace scenarios
        for (int unsigned v = 0; v < 4; v++) begin
            fill_formula(vecs[v].c);
            start_tb(vecs[v].tb_st);
            for (int unsigned k = 0; k < vecs[v].c; k++)
                expect_out("vec", vecs[v].exp_st[k], 4'(vecs[v].c - 1 - k),
                           k == vecs[v].c - 1);
            expect_idle("vec.end");
        end

        // Overwrite within one step: last write wins
        bp_write(4'd2, 4'd1, 1'b0);
        bp_write(4'd2, 4'd9, 1'b0);
        bp_write(4'd15, 4'd0, 1'b1);
        start_tb(4'd2);
        expect_out("ow1", 4'd2, 4'd0, 1'b1);
        expect_idle("ow1.end");
        for (int unsigned x = 0; x < 16; x++)
            bp_write(4'(x), 4'd0, x == 15);
        bp_write(4'd2, 4'd1, 1'b0);
        bp_write(4'd2, 4'd9, 1'b0);
        bp_write(4'd15, 4'd0, 1'b1);
        start_tb(4'd2);
        expect_out("ow2a", 4'd2, 4'd1, 1'b0);
        expect_out("ow2b", 4'd9, 4'd0, 1'b1);
        expect_idle("ow2.end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
